// File: rtl/cordic_pkg.sv
// Shared CORDIC front-end definitions: float32 angle thresholds, quadrant and
// scheduler state encodings, and a NaN helper.
package cordic_pkg;

   localparam logic [31:0] PI_F32          = 32'h40490FDB;
   localparam logic [31:0] HALF_PI_F32     = 32'h3FC90FDB;
   localparam logic [31:0] ZERO_F32        = 32'h00000000;
   localparam logic [31:0] NEG_HALF_PI_F32 = 32'hBFC90FDB;
   localparam logic [31:0] NEG_PI_F32      = 32'hC0490FDB;

   // Quadrant code consumed by the CORDIC pre-rotation select
   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,  // (0, pi/2]
      QUAD_1 = 2'd1,  // (pi/2, pi]
      QUAD_2 = 2'd2,  // (-pi, -pi/2]
      QUAD_3 = 2'd3   // (-pi/2, 0]
   } quadrant_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CMP_PI   = 3'd1,
      ST_CMP_HPI  = 3'd2,
      ST_CMP_Z    = 3'd3,
      ST_CMP_NHPI = 3'd4,
      ST_CMP_NPI  = 3'd5,
      ST_DONE     = 3'd6
   } state_e;

   function automatic logic is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/cordic_quadrant_sched_if.sv
// Angle-in / classification-out handshake bundle of the quadrant scheduler.
interface cordic_quadrant_sched_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_angle;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_angle;
   logic [1:0]  out_quadrant;
   logic        out_err;
   logic        busy;

   // master: angle source plus result consumer
   modport master (
      output in_valid, in_angle, out_ready,
      input  in_ready, out_valid, out_angle, out_quadrant, out_err, busy
   );

   // slave: the scheduler itself
   modport slave (
      input  in_valid, in_angle, out_ready,
      output in_ready, out_valid, out_angle, out_quadrant, out_err, busy
   );

endinterface

// File: rtl/angle_greater.sv
// Float32 "a > b" by sign/exponent/mantissa ordering; +0 > -0, infinities
// order naturally, NaNs are not special-cased.
module angle_greater (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_gt
);

   logic w_mag_gt;
   logic w_mag_lt;

   assign w_mag_gt = i_a[30:0] > i_b[30:0];
   assign w_mag_lt = i_a[30:0] < i_b[30:0];

   // Different signs: a wins exactly when it is the non-negative one.
   // Both negative: the smaller magnitude is the greater value.
   assign o_gt = (i_a[31] != i_b[31]) ? i_b[31] :
                 (i_a[31] ? w_mag_lt : w_mag_gt);

endmodule

// File: rtl/cordic_quadrant_sched.sv
// Sequential quadrant classifier: walks +pi, +pi/2, 0, -pi/2, -pi with one
// shared comparator, one compare per cycle, and reports quadrant or error.
module cordic_quadrant_sched
   import cordic_pkg::*;
#(
   parameter bit CHECK_NAN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   cordic_quadrant_sched_if.slave  bus
);

   state_e      r_state;
   state_e      w_next;
   logic [31:0] r_angle;
   quadrant_e   r_quad;
   logic        r_err;

   logic [31:0] w_thresh;
   logic        w_gt;
   logic        w_nan;
   logic        w_accept;
   logic        w_done;
   quadrant_e   w_quad_d;
   logic        w_err_d;

   assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
   assign w_nan    = CHECK_NAN && is_nan(r_angle);

   // Threshold mux kept in its own process so the comparator output never
   // feeds back into the block that selects its operand.
   always_comb begin
      w_thresh = ZERO_F32;
      case (r_state)
         ST_CMP_PI:   w_thresh = PI_F32;
         ST_CMP_HPI:  w_thresh = HALF_PI_F32;
         ST_CMP_Z:    w_thresh = ZERO_F32;
         ST_CMP_NHPI: w_thresh = NEG_HALF_PI_F32;
         ST_CMP_NPI:  w_thresh = NEG_PI_F32;
         default:     w_thresh = ZERO_F32;
      endcase
   end

   angle_greater u_cmp (
      .i_a  (r_angle),
      .i_b  (w_thresh),
      .o_gt (w_gt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      // NOTE: all outputs of this process get a default first, so no branch
      // can leave one unassigned and infer a latch.
      w_next   = r_state;
      w_done   = 1'b0;
      w_quad_d = QUAD_0;
      w_err_d  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) w_next = ST_CMP_PI;
         end
         ST_CMP_PI: begin
            if (w_nan || w_gt) begin
               w_done  = 1'b1;
               w_err_d = 1'b1;
            end else begin
               w_next = ST_CMP_HPI;
            end
         end
         ST_CMP_HPI: begin
            if (w_gt) begin
               w_done   = 1'b1;
               w_quad_d = QUAD_1;
            end else begin
               w_next = ST_CMP_Z;
            end
         end
         ST_CMP_Z: begin
            if (w_gt) begin
               w_done   = 1'b1;
               w_quad_d = QUAD_0;
            end else begin
               w_next = ST_CMP_NHPI;
            end
         end
         ST_CMP_NHPI: begin
            if (w_gt) begin
               w_done   = 1'b1;
               w_quad_d = QUAD_3;
            end else begin
               w_next = ST_CMP_NPI;
            end
         end
         ST_CMP_NPI: begin
            // Last rung: anything not above -pi (including -pi itself) is out of range
            w_done = 1'b1;
            if (w_gt) w_quad_d = QUAD_2;
            else      w_err_d  = 1'b1;
         end
         ST_DONE: begin
            if (bus.out_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_done) w_next = ST_DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_angle <= 32'd0;
         r_quad  <= QUAD_0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) r_angle <= bus.in_angle;
         if (w_done) begin
            r_quad <= w_quad_d;
            r_err  <= w_err_d;
         end
      end
   end

   assign bus.in_ready     = (r_state == ST_IDLE);
   assign bus.busy         = (r_state != ST_IDLE);
   assign bus.out_valid    = (r_state == ST_DONE);
   assign bus.out_angle    = r_angle;
   assign bus.out_quadrant = r_quad;
   assign bus.out_err      = r_err;

endmodule

// File: tb/tb_cordic_quadrant_sched.sv
// Self-checking bench for cordic_quadrant_sched: vector table through a
// scoreboard queue, plus reset-mid-compare, preheld ready and backpressure.
module tb_cordic_quadrant_sched;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_quadrant_sched_if bus ();

   cordic_quadrant_sched #(.CHECK_NAN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] angle;
      logic [1:0]  quad;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      vec_t v;
      int   acc_cyc;
   } sb_item_t;

   sb_item_t sb_q[$];
   vec_t     vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic accept(input vec_t v);
      sb_item_t it;
      int       wait_cyc;
      bus.in_angle = v.angle;
      bus.in_valid = 1'b1;
      wait_cyc = 0;
      while (!bus.in_ready && wait_cyc < 40) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      if (!bus.in_ready) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: in_ready stayed low, expected high");
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      it.v       = v;
      it.acc_cyc = cyc;
      sb_q.push_back(it);
      check("accept_busy", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic collect(input int stall);
      sb_item_t    e;
      int          waited;
      logic [31:0] h_angle;
      logic [1:0]  h_quad;
      logic        h_err;
      if (sb_q.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL sb_empty: no expected result queued");
         return;
      end
      e = sb_q.pop_front();
      waited = 0;
      while (!bus.out_valid && waited < 24) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!bus.out_valid) begin
         n_vec++; n_err++;
         $display("FAIL out_timeout: out_valid low, expected high for angle %h", e.v.angle);
         return;
      end
      check("latency",  cyc - e.acc_cyc,           e.v.lat);
      check("quadrant", {30'd0, bus.out_quadrant}, {30'd0, e.v.quad});
      check("err",      {31'd0, bus.out_err},      {31'd0, e.v.err});
      check("angle",    bus.out_angle,             e.v.angle);
      h_angle = bus.out_angle;
      h_quad  = bus.out_quadrant;
      h_err   = bus.out_err;
      repeat (stall) begin
         @(posedge clk); #1;
         check("hold_valid",    {31'd0, bus.out_valid},    32'd1);
         check("hold_in_ready", {31'd0, bus.in_ready},     32'd0);
         check("hold_quad",     {30'd0, bus.out_quadrant}, {30'd0, h_quad});
         check("hold_err",      {31'd0, bus.out_err},      {31'd0, h_err});
         check("hold_angle",    bus.out_angle,             h_angle);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("drain_valid",    {31'd0, bus.out_valid}, 32'd0);
      check("drain_in_ready", {31'd0, bus.in_ready},  32'd1);
   endtask

   initial begin
      vec_t v;

      vecs[0]  = '{32'h3F800000, 2'd0, 1'b0, 3};  // 1.0
      vecs[1]  = '{32'h40000000, 2'd1, 1'b0, 2};  // 2.0
      vecs[2]  = '{32'hBF800000, 2'd3, 1'b0, 4};  // -1.0
      vecs[3]  = '{32'hC0000000, 2'd2, 1'b0, 5};  // -2.0
      vecs[4]  = '{32'h00000000, 2'd3, 1'b0, 4};  // +0
      vecs[5]  = '{32'h80000000, 2'd3, 1'b0, 4};  // -0
      vecs[6]  = '{32'h40490FDB, 2'd1, 1'b0, 2};  // +pi
      vecs[7]  = '{32'h7F800000, 2'd0, 1'b1, 1};  // +Inf
      vecs[8]  = '{32'hFF800000, 2'd0, 1'b1, 5};  // -Inf
      vecs[9]  = '{32'hC0490FDB, 2'd0, 1'b1, 5};  // -pi
      vecs[10] = '{32'h7FC00000, 2'd0, 1'b1, 1};  // +NaN
      vecs[11] = '{32'hFFC00000, 2'd0, 1'b1, 1};  // -NaN
      vecs[12] = '{32'h3FC90FDB, 2'd0, 1'b0, 3};  // +pi/2
      vecs[13] = '{32'hBFC90FDB, 2'd2, 1'b0, 5};  // -pi/2
      vecs[14] = '{32'h40490FDC, 2'd0, 1'b1, 1};  // just above +pi
      vecs[15] = '{32'hC0490FDA, 2'd2, 1'b0, 5};  // just above -pi

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_angle = 32'd0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_in_ready",  {31'd0, bus.in_ready},     32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid},    32'd0);
      check("rst_busy",      {31'd0, bus.busy},         32'd0);
      check("rst_angle",     bus.out_angle,             32'd0);
      check("rst_quad",      {30'd0, bus.out_quadrant}, 32'd0);
      check("rst_err",       {31'd0, bus.out_err},      32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         accept(vecs[i]);
         collect(0);
      end

      // Reset while in CMP_Z: the angle is dropped and nothing comes out
      v = '{32'hBF800000, 2'd3, 1'b0, 4};
      accept(v);
      void'(sb_q.pop_back());
      repeat (2) @(posedge clk);
      #1;
      check("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_angle",     bus.out_angle,          32'd0);
      #5;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         check("post_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end

      // out_ready already high before DONE: result shown for one cycle only
      bus.out_ready = 1'b1;
      accept('{32'h3F800000, 2'd0, 1'b0, 3});
      bus.out_ready = 1'b1;
      collect(0);

      // Backpressure with a second angle pending during the whole stall
      accept('{32'h40000000, 2'd1, 1'b0, 2});
      bus.in_angle = 32'hC0000000;
      bus.in_valid = 1'b1;
      collect(10);
      accept('{32'hC0000000, 2'd2, 1'b0, 5});
      check("pending_accept_cycle", bus.out_angle, 32'hC0000000);
      collect(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cordic_quadrant_sched.md
# cordic_quadrant_sched

Sequential quadrant classifier placed in front of the CORDIC rotation core. It accepts one IEEE-754 single-precision angle in radians and walks a fixed threshold ladder (+π, +π/2, 0, −π/2, −π) using one shared `angle_greater` comparator, one comparison per cycle. It reports the quadrant that drives CORDIC pre-rotation selection, or a range/NaN error. Valid/ready handshakes are used on both sides.

## Interface
- `CHECK_NAN`, default 1: when 1, a NaN input (exp = 8'hFF, mantissa ≠ 0) is flagged as an error on the first compare cycle.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input angle valid.
- `in_ready`  out  1  block can accept an angle; high only in IDLE.
- `in_angle`  in  32  IEEE-754 single-precision angle, radians.
- `out_valid`  out  1  classification result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_angle`  out  32  registered copy of the accepted angle.
- `out_quadrant`  out  2  0: (0, π/2]; 1: (π/2, π]; 2: (−π, −π/2]; 3: (−π/2, 0].
- `out_err`  out  1  angle is outside (−π, π], or is NaN when `CHECK_NAN` = 1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CMP_PI, CMP_HPI, CMP_Z, CMP_NHPI, CMP_NPI, DONE.
- IDLE: `in_ready` = 1. On `in_valid & in_ready`, register `in_angle` into `angle_q` and go to CMP_PI.
- Each CMP state drives the comparator with `a = angle_q` and `b` = the state's constant. `gt` is the comparator output.
  - CMP_PI, b = 32'h40490FDB: `gt` → err. Under `CHECK_NAN`, NaN → err, taking priority. Otherwise go to CMP_HPI.
  - CMP_HPI, b = 32'h3FC90FDB: `gt` → quadrant 1. Otherwise go to CMP_Z.
  - CMP_Z, b = 32'h00000000: `gt` → quadrant 0. Otherwise go to CMP_NHPI. Both +0 and −0 fall through.
  - CMP_NHPI, b = 32'hBFC90FDB: `gt` → quadrant 3. Otherwise go to CMP_NPI.
  - CMP_NPI, b = 32'hC0490FDB: `gt` → quadrant 2. Otherwise → err. Exactly −π is an error.
- Any terminating decision loads `out_quadrant` and `out_err` and moves to DONE. On err, `out_quadrant` = 0.
- DONE: `out_valid` = 1. Outputs hold stable until `out_ready`; then go to IDLE.
- Comparator semantics are sign/exponent/mantissa magnitude ordering, with +0 > −0. Infinities order naturally: +Inf and −Inf both → err.
- No pipelining. One angle is in flight at a time, and `in_angle` is ignored outside IDLE.

## Timing
- Reset (async assert, synchronous deassert into IDLE): state = IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_angle` = 0, `out_quadrant` = 0, `out_err` = 0.
- Latency: `out_valid` rises N cycles after the accepting edge, where N = number of compares. The values of N are:
  - 1: err high or NaN.
  - 2: quadrant 1.
  - 3: quadrant 0.
  - 4: quadrant 3.
  - 5: quadrant 2, or err low.
- Output handshake completes on the edge where `out_valid & out_ready`. `in_ready` is high the following cycle.
  - Minimum period between accepts is N + 2 cycles.
- `out_ready` held high before DONE: the result is still presented for exactly one cycle, then the block returns to IDLE.
- `in_valid` asserted while busy: no effect; the source holds the angle until `in_ready`.
- `rst_n` low mid-operation: immediate return to IDLE with reset outputs. The in-flight angle is dropped and no `out_valid` pulse occurs.
- Comparator path is combinational within one cycle (register → mux → compare → next-state).

## Structure
- The shared `cordic_pkg` holds:
  - the threshold constants `PI_F32`, `HALF_PI_F32`, `NEG_HALF_PI_F32`, `NEG_PI_F32`, `ZERO_F32`;
  - the quadrant encoding;
  - the state encoding.
- One sub-module: a single instance of the existing `angle_greater` comparator. The `b` operand is muxed by state.
- The threshold mux and NaN detect live in this block.

## Test plan
- Reset mid-compare: assert `rst_n` = 0 while in CMP_Z → `in_ready` = 1 and `out_valid` = 0 immediately; no result emitted after release.
- Accept 32'h3F800000 (1.0) → `out_valid` 3 cycles after accept, `out_quadrant` = 0, `out_err` = 0. Accept 32'h40000000 (2.0) → 2 cycles, `out_quadrant` = 1.
- Accept 32'hBF800000 (−1.0) → 4 cycles, `out_quadrant` = 3. Accept 32'hC0000000 (−2.0) → 5 cycles, `out_quadrant` = 2.
- Accept 32'h00000000 and 32'h80000000 → both give `out_quadrant` = 3 after 4 cycles. Accept 32'h40490FDB (+π) → `out_quadrant` = 1.
- Accept 32'h7F800000 (+Inf) → err after 1 cycle. Accept 32'hC0490FDB (−π) → err after 5 cycles. Accept 32'h7FC00000 (NaN, `CHECK_NAN` = 1) → err after 1 cycle.
- Backpressure: `out_ready` = 0 for 10 cycles with a new `in_valid` pending → outputs stable, `in_ready` = 0. Release → result consumed, and the pending angle is accepted the next cycle.
